// File: rtl/datapath_reg_alu_pipe.sv
// Two-stage register-file / ALU / data-memory datapath: stage 1 issues and reads operands
// (with write-back forwarding), stage 2 executes, accesses memory and writes back.
module datapath_reg_alu_pipe #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned REG_ADDR  = 5,
  parameter int unsigned ZERO_REG  = 31,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cw_valid,
  output logic                cw_ready,
  input  logic [REG_ADDR-1:0] DA,
  input  logic [REG_ADDR-1:0] SA,
  input  logic [REG_ADDR-1:0] SB,
  input  logic                W,
  input  logic [WIDTH-1:0]    K,
  input  logic                BS,
  input  logic [4:0]          FS,
  input  logic                mem_write,
  input  logic                sel_en,
  output logic [3:0]          status,
  output logic [WIDTH-1:0]    data,
  output logic                wb_valid,
  output logic                busy
);

  localparam int unsigned ShW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned LatW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned NRegs = 2 ** REG_ADDR;

  localparam logic [REG_ADDR-1:0] ZeroAddr = REG_ADDR'(ZERO_REG);
  localparam logic [LatW-1:0]     LatLast  = LatW'(MEM_LAT - 1);

  // Architectural state
  logic [WIDTH-1:0] regs_q [NRegs];
  logic [WIDTH-1:0] mem_q  [MEM_DEPTH];
  logic [3:0]       status_q, status_d;
  logic [WIDTH-1:0] data_q;

  // Stage-2 register
  logic                s2_valid_q;
  logic [WIDTH-1:0]    s2_a_q, s2_b_q, s2_bfile_q;
  logic [REG_ADDR-1:0] s2_da_q;
  logic                s2_w_q;
  logic [4:0]          s2_fs_q;
  logic                s2_mw_q;
  logic                s2_sel_q;
  logic [LatW-1:0]     lat_q, lat_d;

  logic                s2_is_mem, s2_is_load, s2_final, commit, accept;
  logic                fwd_ok;
  logic [WIDTH-1:0]    a_rd, bfile_rd, b_sel;
  logic [WIDTH-1:0]    a_op, b_op, alu_res, result, mem_rdata;
  logic [WIDTH:0]      sum_ext;
  logic [ShW-1:0]      shamt;
  logic                cin, is_add, flag_v, flag_c, flag_n, flag_z;
  logic [MemAw-1:0]    mem_addr;

  // Control: memory ops hold stage 2 for MEM_LAT cycles, committing in the last one.
  assign s2_is_mem  = s2_mw_q | ~s2_sel_q;
  assign s2_is_load = ~s2_mw_q & ~s2_sel_q;
  assign s2_final   = ~s2_is_mem | (lat_q == LatLast);
  assign commit     = s2_valid_q & s2_final;
  assign cw_ready   = ~(s2_valid_q & ~s2_final);
  assign accept     = cw_valid & cw_ready;

  always_comb begin
    lat_d = '0;
    if (s2_valid_q && s2_is_mem && !s2_final) begin
      lat_d = lat_q + LatW'(1);
    end
  end

  // ALU
  always_comb begin
    a_op    = s2_fs_q[0] ? ~s2_a_q : s2_a_q;
    b_op    = s2_fs_q[1] ? ~s2_b_q : s2_b_q;
    cin     = s2_fs_q[1];
    sum_ext = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    shamt   = b_op[ShW-1:0];
    is_add  = 1'b0;
    alu_res = '0;
    unique case (s2_fs_q[4:2])
      3'b000: alu_res = a_op & b_op;
      3'b001: alu_res = a_op | b_op;
      3'b010: begin
        alu_res = sum_ext[WIDTH-1:0];
        is_add  = 1'b1;
      end
      3'b011: alu_res = a_op ^ b_op;
      3'b100: alu_res = a_op << shamt;
      3'b101: alu_res = a_op >> shamt;
      3'b110, 3'b111: alu_res = a_op;
    endcase
    flag_c = is_add & sum_ext[WIDTH];
    flag_v = is_add & (a_op[WIDTH-1] == b_op[WIDTH-1]) & (sum_ext[WIDTH-1] != a_op[WIDTH-1]);
    flag_n = alu_res[WIDTH-1];
    flag_z = (alu_res == '0);
  end

  assign mem_addr  = MemAw'(alu_res % WIDTH'(MEM_DEPTH));
  assign mem_rdata = mem_q[mem_addr];
  assign result    = s2_is_load ? mem_rdata : alu_res;

  always_comb begin
    status_d = status_q;
    if (commit && !s2_is_mem) begin
      status_d = {flag_v, flag_c, flag_n, flag_z};
    end
  end

  // Operand read with forwarding from the committing stage-2 op
  assign fwd_ok = commit & s2_w_q & (s2_da_q != ZeroAddr);

  always_comb begin
    if (SA == ZeroAddr) begin
      a_rd = '0;
    end else if (fwd_ok && (s2_da_q == SA)) begin
      a_rd = result;
    end else begin
      a_rd = regs_q[SA];
    end
    if (SB == ZeroAddr) begin
      bfile_rd = '0;
    end else if (fwd_ok && (s2_da_q == SB)) begin
      bfile_rd = result;
    end else begin
      bfile_rd = regs_q[SB];
    end
    b_sel = BS ? K : bfile_rd;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_bfile_q <= '0;
      s2_da_q    <= '0;
      s2_w_q     <= 1'b0;
      s2_fs_q    <= '0;
      s2_mw_q    <= 1'b0;
      s2_sel_q   <= 1'b0;
    end else if (cw_ready) begin
      s2_valid_q <= cw_valid;
      if (accept) begin
        s2_a_q     <= a_rd;
        s2_b_q     <= b_sel;
        s2_bfile_q <= bfile_rd;
        s2_da_q    <= DA;
        s2_w_q     <= W;
        s2_fs_q    <= FS;
        s2_mw_q    <= mem_write;
        s2_sel_q   <= sel_en;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_q    <= '0;
      status_q <= '0;
      data_q   <= '0;
    end else begin
      lat_q    <= lat_d;
      status_q <= status_d;
      if (commit) begin
        data_q <= result;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (fwd_ok) begin
      regs_q[s2_da_q] <= result;
    end
  end

  // Memory is not reset; an async reset clears s2_valid_q, so a pending store never lands.
  always_ff @(posedge clock) begin
    if (commit && s2_mw_q) begin
      mem_q[mem_addr] <= s2_bfile_q;
    end
  end

  assign data     = commit ? result : data_q;
  assign status   = status_q;
  assign wb_valid = commit;
  assign busy     = s2_valid_q;

endmodule

// File: tb/tb_datapath_reg_alu_pipe.sv
// Directed bench for datapath_reg_alu_pipe: vector table on a MEM_LAT=2 instance, plus
// hand sequences for load stalls (MEM_LAT=3) and reset during a store.
module tb_datapath_reg_alu_pipe;

  typedef struct packed {
    logic [4:0]  da;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic        w;
    logic [63:0] k;
    logic        bs;
    logic [4:0]  fs;
    logic        mw;
    logic        sel;
  } cw_t;

  typedef struct {
    cw_t         cw;
    logic [63:0] exp_data;
    logic        chk;
    logic [3:0]  exp_status;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst2, rst3, v2, v3, rdy2, rdy3, wb2, wb3, bz2, bz3;
  cw_t         in2, in3;
  logic [3:0]  st2, st3;
  logic [63:0] d2, d3;
  logic [63:0] q2[$];
  logic [63:0] q3[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          s;

  always #5 clock = ~clock;

  datapath_reg_alu_pipe #(.MEM_LAT(2)) dut2 (
    .clock(clock), .reset(rst2), .cw_valid(v2), .cw_ready(rdy2),
    .DA(in2.da), .SA(in2.sa), .SB(in2.sb), .W(in2.w), .K(in2.k), .BS(in2.bs), .FS(in2.fs),
    .mem_write(in2.mw), .sel_en(in2.sel),
    .status(st2), .data(d2), .wb_valid(wb2), .busy(bz2)
  );

  datapath_reg_alu_pipe #(.MEM_LAT(3)) dut3 (
    .clock(clock), .reset(rst3), .cw_valid(v3), .cw_ready(rdy3),
    .DA(in3.da), .SA(in3.sa), .SB(in3.sb), .W(in3.w), .K(in3.k), .BS(in3.bs), .FS(in3.fs),
    .mem_write(in3.mw), .sel_en(in3.sel),
    .status(st3), .data(d3), .wb_valid(wb3), .busy(bz3)
  );

  // Record every committed result in order
  always @(negedge clock) begin
    if (wb2) q2.push_back(d2);
    if (wb3) q3.push_back(d3);
  end

  function automatic cw_t mk(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                             input logic w, input logic [63:0] k, input logic bs,
                             input logic [4:0] fs, input logic mw, input logic sel);
    cw_t c;
    c.da = da; c.sa = sa; c.sb = sb; c.w = w; c.k = k; c.bs = bs; c.fs = fs;
    c.mw = mw; c.sel = sel;
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a control word and hold it until accepted; returns cycles spent not ready.
  task automatic send(input int which, input cw_t c, output int stalls);
    stalls = 0;
    if (which == 2) begin in2 = c; v2 = 1'b1; end
    else begin in3 = c; v3 = 1'b1; end
    for (int n = 0; n <= 20; n++) begin
      @(negedge clock);
      if ((which == 2) ? rdy2 : rdy3) break;
      stalls++;
    end
    if (stalls > 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no cw_ready expected cw_ready within 20 cycles");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int which, input int n);
    if (which == 2) v2 = 1'b0;
    else v3 = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst2 = 1'b0; rst3 = 1'b0; v2 = 1'b0; v3 = 1'b0; in2 = '0; in3 = '0;

    // Reset state
    @(negedge clock);
    check("rst_cw_ready", 64'(rdy2), 64'd1);
    check("rst_busy", 64'(bz2), 64'd0);
    check("rst_wb_valid", 64'(wb2), 64'd0);
    check("rst_data", d2, 64'd0);
    check("rst_status", 64'(st2), 64'd0);
    @(posedge clock); #1;
    rst2 = 1'b1; rst3 = 1'b1;
    @(posedge clock); #1;

    // Back-to-back program with forwarding, then flag cases and zero register
    tbl.push_back('{mk(5, 31, 0, 1, 64'd24, 1, 5'b00100, 0, 1), 64'd24, 0, 4'h0});
    tbl.push_back('{mk(7, 31, 0, 1, 64'd39, 1, 5'b00100, 0, 1), 64'd39, 0, 4'h0});
    tbl.push_back('{mk(1, 5, 7, 1, 64'd0, 0, 5'b01000, 0, 1), 64'd63, 0, 4'h0});
    tbl.push_back('{mk(30, 1, 5, 1, 64'd0, 0, 5'b01100, 0, 1), 64'd39, 0, 4'h0});
    tbl.push_back('{mk(17, 30, 0, 1, 64'd2, 1, 5'b10000, 0, 1), 64'd156, 0, 4'h0});
    tbl.push_back('{mk(0, 7, 17, 0, 64'd0, 1, 5'b00100, 1, 1), 64'd39, 0, 4'h0});
    tbl.push_back('{mk(0, 7, 0, 1, 64'd0, 1, 5'b00100, 0, 0), 64'd156, 0, 4'h0});
    tbl.push_back('{mk(0, 0, 0, 0, 64'd4, 1, 5'b01000, 0, 1), 64'd160, 0, 4'h0});
    tbl.push_back('{mk(1, 31, 0, 1, 64'd63, 1, 5'b00100, 0, 1), 64'd63, 0, 4'h0});
    tbl.push_back('{mk(0, 1, 0, 0, 64'd63, 1, 5'b01010, 0, 1), 64'd0, 1, 4'b0101});
    tbl.push_back('{mk(2, 31, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 5'b00100, 0, 1),
                    64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h0});
    tbl.push_back('{mk(0, 2, 0, 0, 64'd1, 1, 5'b01000, 0, 1), 64'h8000_0000_0000_0000, 1,
                    4'b1010});
    tbl.push_back('{mk(31, 31, 0, 1, 64'd5, 1, 5'b00100, 0, 1), 64'd5, 0, 4'h0});
    tbl.push_back('{mk(0, 31, 0, 0, 64'd0, 1, 5'b00100, 0, 1), 64'd0, 0, 4'h0});
    tbl.push_back('{mk(8, 17, 0, 1, 64'd1, 1, 5'b10100, 0, 1), 64'd78, 0, 4'h0});
    tbl.push_back('{mk(9, 8, 0, 1, 64'd15, 1, 5'b00000, 0, 1), 64'd14, 0, 4'h0});
    tbl.push_back('{mk(0, 9, 0, 0, 64'd0, 1, 5'b11001, 0, 1), 64'hFFFF_FFFF_FFFF_FFF1, 1,
                    4'b0010});

    q2.delete();
    foreach (tbl[i]) begin
      send(2, tbl[i].cw, s);
      if (tbl[i].chk) begin
        idle(2, 2);
        check($sformatf("vec%0d_status", i), 64'(st2), 64'(tbl[i].exp_status));
      end
    end
    idle(2, 4);
    check("vec_commit_count", 64'(q2.size()), 64'(tbl.size()));
    foreach (tbl[i]) begin
      if (i < q2.size()) check($sformatf("vec%0d_data", i), q2[i], tbl[i].exp_data);
    end

    // Load stall with MEM_LAT=3 and a dependent op issued in the load's final cycle
    q3.delete();
    send(3, mk(4, 31, 0, 1, 64'd77, 1, 5'b00100, 0, 1), s);
    send(3, mk(0, 31, 4, 0, 64'd20, 1, 5'b00100, 1, 1), s);
    send(3, mk(6, 31, 0, 1, 64'd20, 1, 5'b00100, 0, 0), s);
    check("store_stall_cycles", 64'(s), 64'd2);
    send(3, mk(7, 6, 0, 1, 64'd1, 1, 5'b01000, 0, 1), s);
    check("load_stall_cycles", 64'(s), 64'd2);
    idle(3, 5);
    check("lat3_commit_count", 64'(q3.size()), 64'd4);
    if (q3.size() == 4) begin
      check("lat3_r4", q3[0], 64'd77);
      check("lat3_store_addr", q3[1], 64'd20);
      check("lat3_load", q3[2], 64'd77);
      check("lat3_dependent", q3[3], 64'd78);
    end

    // Reset during the final cycle of a store must leave memory untouched
    send(2, mk(3, 31, 0, 1, 64'd7, 1, 5'b00100, 0, 1), s);
    send(2, mk(0, 31, 3, 0, 64'd10, 1, 5'b00100, 1, 1), s);
    send(2, mk(4, 31, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'b00100, 0, 1), s);
    send(2, mk(0, 31, 4, 0, 64'd10, 1, 5'b00100, 1, 1), s);
    v2 = 1'b0;
    @(posedge clock); #1;
    check("pre_reset_busy", 64'(bz2), 64'd1);
    check("pre_reset_status", 64'(st2), 64'b0010);
    rst2 = 1'b0;
    #1;
    check("mid_reset_cw_ready", 64'(rdy2), 64'd1);
    check("mid_reset_busy", 64'(bz2), 64'd0);
    check("mid_reset_status", 64'(st2), 64'd0);
    check("mid_reset_wb_valid", 64'(wb2), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    rst2 = 1'b1;
    @(posedge clock); #1;
    check("post_reset_status", 64'(st2), 64'd0);
    check("post_reset_data", d2, 64'd0);

    q2.delete();
    for (int i = 0; i < 32; i++) begin
      send(2, mk(0, 5'(i), 0, 0, 64'd0, 1, 5'b00100, 0, 1), s);
    end
    send(2, mk(1, 31, 0, 1, 64'd10, 1, 5'b00100, 0, 0), s);
    idle(2, 4);
    check("post_reset_commit_count", 64'(q2.size()), 64'd33);
    if (q2.size() == 33) begin
      for (int i = 0; i < 32; i++) check($sformatf("post_reset_r%0d", i), q2[i], 64'd0);
      check("mem10_kept", q2[32], 64'd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_reg_alu_pipe.md
Name: datapath_reg_alu_pipe

Overview:
Parametrised successor to the single-cycle register-file/ALU/RAM datapath. It accepts one control word per cycle over a valid/ready handshake and runs it through a 2-stage pipeline: issue/operand-read, then execute/memory/write-back. Operands are forwarded from the write-back stage. Data-memory access takes a configurable number of cycles and stalls issue. It sits between the control unit (control-word source) and the rest of the CPU (status flags, data bus).

Parameters:
WIDTH, 64, datapath and register width
REG_ADDR, 5, register address bits (2**REG_ADDR registers)
ZERO_REG, 31, register that always reads 0; writes to it are dropped
MEM_DEPTH, 256, data-memory words (address = ALU result mod MEM_DEPTH)
MEM_LAT, 2, cycles a load/store occupies stage 2 (>=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cw_valid  in  1  control word present
cw_ready  out  1  control word accepted this cycle when valid&ready
DA  in  REG_ADDR  destination register
SA  in  REG_ADDR  source A register
SB  in  REG_ADDR  source B register
W  in  1  register write enable
K  in  WIDTH  constant
BS  in  1  B select: 1=K, 0=reg[SB]
FS  in  5  ALU function select
mem_write  in  1  store reg[SB] to M[ALU result]
sel_en  in  1  result select: 1=ALU, 0=memory read data
status  out  4  {V,C,N,Z}
data  out  WIDTH  stage-2 result bus
wb_valid  out  1  stage 2 commits this cycle
busy  out  1  stage 2 holds a valid op

Behaviour:
- Reset (async, reset=0): all registers = 0; stage-2 valid = 0; memory-latency counter = 0; status = 0; data = 0; wb_valid = 0; busy = 0; cw_ready = 1. Memory contents are not reset.
- Stage 1 (accept cycle N):
  - Read A=reg[SA] and Bfile=reg[SB], with forwarding: if stage 2 commits this cycle with W=1, DA!=ZERO_REG, and DA==SA or DA==SB, use the stage-2 result.
  - B = BS ? K : Bfile.
  - Latch A, B, Bfile (store data), DA, W, FS, mem_write, sel_en into the stage-2 register.
- ALU (stage 2): FS[0] inverts A; FS[1] inverts B and sets carry-in=1. FS[4:2]:
  - 000 AND
  - 001 OR
  - 010 ADD (A'+B'+cin)
  - 011 XOR
  - 100 shift left A by B[log2(WIDTH)-1:0]
  - 101 logical shift right A by B[log2(WIDTH)-1:0]
  - 110/111 pass A
- Flags:
  - C = adder carry-out (ADD only, else 0).
  - V = signed overflow (ADD only, else 0).
  - N = result[WIDTH-1].
  - Z = (result==0).
- ALU op (mem_write=0, sel_en=1): commits in cycle N+1.
  - data = ALU result.
  - reg[DA] written at the N+1 edge if W.
  - status updated at that edge.
  - wb_valid=1 in N+1.
- Load (mem_write=0, sel_en=0):
  - Occupies stage 2 for MEM_LAT cycles and commits in the last one.
  - data = M[ALU result]; written to DA if W.
  - status unchanged.
- Store (mem_write=1, sel_en ignored):
  - Occupies stage 2 for MEM_LAT cycles.
  - M[ALU result] <= Bfile at the final-cycle edge.
  - data = ALU result; written to DA if W.
  - status unchanged.
- Handshake and stalls:
  - cw_ready = 0 while stage 2 holds a memory op that is not in its final cycle; otherwise 1. The final cycle allows a back-to-back issue with forwarding.
  - When MEM_LAT=1, a memory op takes 1 cycle (no stall).
  - No-op cycle (cw_valid=0 when ready): stage-2 valid clears; data holds its last value; wb_valid=0.
- ZERO_REG: reads 0, never a forwarding source, writes dropped (wb_valid still 1).
- Reset mid-operation: a pending store never writes memory; an uncommitted load or ALU result is lost.
- Same register as SA/SB and DA: the old value is read (or forwarded), and the new value is written at commit.

Test Plan:
1. Back-to-back, MEM_LAT=2, cw_valid held:
   - R5=24 (SA=31, K=24, BS=1, FS=00100)
   - R7=39 (SA=31, K=39, BS=1, FS=00100)
   - R1=R5+R7 (FS=01000)
   - R30=R1^R5 (FS=01100)
   - R17=R30<<2 (K=2, FS=10000)
   - Store M[R7]=R17 (SA=7, SB=17, K=0, FS=00100, mem_write=1, W=0)
   - R0=M[R7] (sel_en=0)
   - R0+4 with W=0
   - -> data sequence 24, 39, 63, 39, 156, 39, 156, 160; forwarding is exercised on every dependent op.
2. R1=63, then SA=1, K=63, BS=1, FS=01010 (SUB) -> data=0, status={V0,C1,N0,Z1}.
3. R2=0x7FFF_FFFF_FFFF_FFFF, then R2+K=1 -> data=0x8000_0000_0000_0000, status={V1,C0,N1,Z0}.
4. DA=31, K=5, W=1; then SA=31 OR K=0 -> data=0; register 31 still reads 0.
5. Load stall, MEM_LAT=3, load issued, next op (cw_valid=1) reads the loaded register -> cw_ready low for 2 cycles; the dependent op sees the loaded value; wb_valid pulses once for the load.
6. Reset=0 during the 2nd cycle of a store to M[10] (old value 7) -> M[10] stays 7; after release all registers = 0, status=0, cw_ready=1, busy=0.
